// File: rtl/matmul_requant_fifo.sv
// Requantisation stage behind the 5x5 systolic array: per-lane bias, rounding shift,
// optional ReLU and int8 saturation, then a valid/ready FIFO carrying a per-frame last marker.
module matmul_requant_fifo #(
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 10
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [79:0]            RES_i,
    input  logic                   RES_VAL_i,
    input  logic                   RES_OV_i,
    input  logic [79:0]            BIAS_i,
    input  logic [3:0]             SHIFT_i,
    input  logic                   RELU_i,
    input  logic                   CLR_i,
    output logic [39:0]            OUT_o,
    output logic                   OUT_SAT_o,
    output logic                   OUT_LAST_o,
    output logic                   OUT_VAL_o,
    input  logic                   OUT_RDY_i,
    output logic                   DROP_o,
    output logic [$clog2(DEPTH):0] LEVEL_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int EW = 42;

    logic [4:0][16:0]   sum_d, sum_q;
    logic               s1_val_q, s1_ov_q;
    logic [39:0]        row_d, row_q;
    logic [4:0]         clip;
    logic               s2_val_q, s2_sat_q;
    logic signed [17:0] rnd;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic [CW-1:0]      cnt_q;
    logic               drop_q;
    logic [39:0]        out_data_q;
    logic               out_sat_q, out_last_q;
    logic               full, pop, push, last;
    logic [EW-1:0]      wdata, head_d;

    genvar gi;

    // S1: 17-bit sum cannot overflow for any 16-bit lane/bias pair.
    generate
        for (gi = 0; gi < 5; gi++) begin : g_s1
            assign sum_d[gi] = {RES_i[79-16*gi], RES_i[79-16*gi -: 16]}
                             + {BIAS_i[79-16*gi], BIAS_i[79-16*gi -: 16]};
        end
    endgenerate

    assign rnd = (SHIFT_i == 4'd0) ? 18'sd0 : (18'sd1 <<< (SHIFT_i - 4'd1));

    generate
        for (gi = 0; gi < 5; gi++) begin : g_s2
            logic signed [17:0] biased;
            logic signed [17:0] shifted;
            logic [7:0]         q8;
            logic               clp;
            always_comb begin
                biased  = $signed({sum_q[gi][16], sum_q[gi]}) + rnd;
                shifted = biased >>> SHIFT_i;
                if (RELU_i && shifted[17]) begin
                    shifted = '0;
                end
                q8  = shifted[7:0];
                clp = 1'b0;
                if (shifted > 18'sd127) begin
                    q8  = 8'h7F;
                    clp = 1'b1;
                end else if (shifted < -18'sd128) begin
                    q8  = 8'h80;
                    clp = 1'b1;
                end
            end
            assign row_d[39-8*gi -: 8] = q8;
            assign clip[gi]            = clp;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            s1_val_q <= 1'b0;
            s1_ov_q  <= 1'b0;
            sum_q    <= '0;
            s2_val_q <= 1'b0;
            s2_sat_q <= 1'b0;
            row_q    <= '0;
        end else begin
            s1_val_q <= RES_VAL_i && !CLR_i;
            s1_ov_q  <= RES_OV_i;
            sum_q    <= sum_d;
            s2_val_q <= s1_val_q && !CLR_i;
            s2_sat_q <= (|clip) || s1_ov_q;
            row_q    <= row_d;
        end
    end

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign pop   = OUT_VAL_o && OUT_RDY_i;
    assign push  = s2_val_q && (!full || pop);
    assign last  = (cnt_q == CW'(FRAME_LEN - 1));
    assign wdata = {last, s2_sat_q, row_q};

    // Head register tracks the entry at the next read pointer; a write into an
    // otherwise empty slot is forwarded since the array has not been updated yet.
    always_comb begin
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
        head_d   = {out_last_q, out_sat_q, out_data_q};
        if (level_d != '0) begin
            head_d = (push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
        end
    end

    always_ff @(posedge CLK) begin
        if (push && !CLR_i) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else if (CLR_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (s2_val_q) begin
                cnt_q <= last ? '0 : cnt_q + CW'(1);
            end
            if (s2_val_q && !push) begin
                drop_q <= 1'b1;
            end
            {out_last_q, out_sat_q, out_data_q} <= head_d;
        end
    end

    assign OUT_o      = out_data_q;
    assign OUT_SAT_o  = out_sat_q;
    assign OUT_LAST_o = out_last_q;
    assign OUT_VAL_o  = (level_q != '0);
    assign DROP_o     = drop_q;
    assign LEVEL_o    = level_q;

endmodule

// File: tb/tb_matmul_requant_fifo.sv
// Bench for matmul_requant_fifo: scenario tasks checked against an arithmetic
// reference of the requantisation plus a queue model of the buffered rows.
module tb_matmul_requant_fifo;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 10;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [79:0] RES_i = '0;
    logic        RES_VAL_i = 1'b0;
    logic        RES_OV_i = 1'b0;
    logic [79:0] BIAS_i = '0;
    logic [3:0]  SHIFT_i = '0;
    logic        RELU_i = 1'b0;
    logic        CLR_i = 1'b0;
    logic [39:0] OUT_o;
    logic        OUT_SAT_o, OUT_LAST_o, OUT_VAL_o;
    logic        OUT_RDY_i = 1'b0;
    logic        DROP_o;
    logic [4:0]  LEVEL_o;

    matmul_requant_fifo #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .CLK(CLK), .RSTN(RSTN), .RES_i(RES_i), .RES_VAL_i(RES_VAL_i), .RES_OV_i(RES_OV_i),
        .BIAS_i(BIAS_i), .SHIFT_i(SHIFT_i), .RELU_i(RELU_i), .CLR_i(CLR_i),
        .OUT_o(OUT_o), .OUT_SAT_o(OUT_SAT_o), .OUT_LAST_o(OUT_LAST_o), .OUT_VAL_o(OUT_VAL_o),
        .OUT_RDY_i(OUT_RDY_i), .DROP_o(DROP_o), .LEVEL_o(LEVEL_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [39:0] d;
        logic        sat;
        logic        last;
    } ent_t;

    ent_t mq[$];
    ent_t p1, p2;
    bit   p1v = 0, p2v = 0, drop_m = 0;
    int   fcnt = 0;
    int   total = 0, bad = 0;

    // Integer reference: floor((x + half) / 2^sh) without shift operators on the data.
    function automatic ent_t requant(input logic [79:0] r, input logic [79:0] b,
                                     input int sh, input bit relu, input bit ov);
        ent_t e;
        int   x, d, y;
        bit   clipped = 0;
        e.d = '0;
        for (int l = 0; l < 5; l++) begin
            x = int'($signed(r[79-16*l -: 16])) + int'($signed(b[79-16*l -: 16]));
            d = 1 << sh;
            if (sh > 0) x = x + d / 2;
            y = (x >= 0) ? x / d : -((-x + d - 1) / d);
            if (relu && y < 0) y = 0;
            if (y > 127) begin y = 127; clipped = 1; end
            else if (y < -128) begin y = -128; clipped = 1; end
            e.d[39-8*l -: 8] = y[7:0];
        end
        e.sat  = clipped || ov;
        e.last = 1'b0;
        return e;
    endfunction

    function automatic logic [79:0] rand_row();
        logic [79:0] r;
        for (int l = 0; l < 5; l++)
            r[16*l +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                         : 16'($urandom_range(0, 4000) - 2000);
        return r;
    endfunction

    // Drive one cycle of inputs and advance the model across the clock edge.
    task automatic step(input logic v, input logic [79:0] r, input logic ov,
                        input logic rdy, input logic clr);
        ent_t e;
        bit   pop_m;
        RES_VAL_i = v; RES_i = r; RES_OV_i = ov; OUT_RDY_i = rdy; CLR_i = clr;
        e     = requant(r, BIAS_i, int'(SHIFT_i), RELU_i, ov);
        pop_m = (mq.size() > 0) && rdy;
        @(posedge CLK);
        if (clr) begin
            mq.delete(); p1v = 0; p2v = 0; fcnt = 0; drop_m = 0;
        end else begin
            if (pop_m) mq.delete(0);
            if (p2v) begin
                p2.last = (fcnt == FRAME_LEN - 1);
                fcnt    = (fcnt + 1) % FRAME_LEN;
                if (mq.size() < DEPTH) mq.push_back(p2);
                else drop_m = 1;
            end
            p2 = p1; p2v = p1v; p1 = e; p1v = v;
        end
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({OUT_o, OUT_SAT_o, OUT_LAST_o, OUT_VAL_o, DROP_o, LEVEL_o} !== 49'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {OUT_o, OUT_SAT_o, OUT_LAST_o, OUT_VAL_o, DROP_o, LEVEL_o});
        end
    endtask

    task automatic test_directed();
        logic [79:0] row;
        row = {16'd100, 16'hFF9C, 16'd7, 16'd8, 16'd0};
        BIAS_i = '0; SHIFT_i = 4'd2; RELU_i = 1'b0;
        step(0, '0, 0, 0, 1);
        step(1, row, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        total++;
        if (OUT_VAL_o !== 1'b0) begin
            bad++; $display("FAIL no_bypass val=%b want=0", OUT_VAL_o);
        end
        step(0, '0, 0, 0, 0);
        total++;
        if ({OUT_VAL_o, LEVEL_o, OUT_SAT_o, OUT_LAST_o, OUT_o} !== {1'b1, 5'd1, 1'b0, 1'b0, 40'h19E7020200}) begin
            bad++;
            $display("FAIL directed_row got=%h want=%h",
                     {OUT_VAL_o, LEVEL_o, OUT_SAT_o, OUT_LAST_o, OUT_o},
                     {1'b1, 5'd1, 1'b0, 1'b0, 40'h19E7020200});
        end
        step(0, '0, 0, 1, 0);
        total++;
        if ({OUT_VAL_o, LEVEL_o} !== 6'd0) begin
            bad++; $display("FAIL directed_drain got=%h want=0", {OUT_VAL_o, LEVEL_o});
        end
    endtask

    task automatic test_sat_relu();
        logic [79:0] rows [3];
        logic        relus[3];
        logic        ovs  [3];
        logic [40:0] exps [3];
        rows[0] = {16'h03E8, 16'hFC18, 16'hFFFB, 16'h007F, 16'h0080};
        rows[1] = rows[0];
        rows[2] = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        relus[0] = 1; relus[1] = 0; relus[2] = 0;
        ovs[0] = 0; ovs[1] = 0; ovs[2] = 1;
        exps[0] = {1'b1, 40'h7F00007F7F};
        exps[1] = {1'b1, 40'h7F80FB7F7F};
        exps[2] = {1'b1, 40'h0102030405};
        BIAS_i = '0; SHIFT_i = 4'd0;
        step(0, '0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            RELU_i = relus[i];
            step(1, rows[i], ovs[i], 0, 0);
            step(0, '0, 0, 0, 0);
            step(0, '0, 0, 0, 0);
            total++;
            if ({OUT_SAT_o, OUT_o} !== exps[i]) begin
                bad++; $display("FAIL sat_relu_%0d got=%h want=%h", i, {OUT_SAT_o, OUT_o}, exps[i]);
            end
            step(0, '0, 0, 1, 0);
        end
        RELU_i = 1'b0;
    endtask

    task automatic test_frame();
        int          popped = 0;
        logic [31:0] lastmask = '0;
        BIAS_i = {5{16'($urandom_range(0, 200) - 100)}}; SHIFT_i = 4'd3;
        step(0, '0, 0, 1, 1);
        for (int c = 0; c < 36; c++) begin
            total++;
            if ({OUT_VAL_o, LEVEL_o, DROP_o} !== {mq.size() != 0, 5'(mq.size()), drop_m}) begin
                bad++; $display("FAIL frame_level c=%0d got=%h want=%h", c,
                                {OUT_VAL_o, LEVEL_o, DROP_o}, {mq.size() != 0, 5'(mq.size()), drop_m});
            end
            if (OUT_VAL_o && mq.size() > 0) begin
                total++;
                if ({OUT_LAST_o, OUT_SAT_o, OUT_o} !== {mq[0].last, mq[0].sat, mq[0].d}) begin
                    bad++; $display("FAIL frame_head c=%0d got=%h want=%h", c,
                                    {OUT_LAST_o, OUT_SAT_o, OUT_o}, {mq[0].last, mq[0].sat, mq[0].d});
                end
                popped++;
                if (OUT_LAST_o && popped < 32) lastmask[popped] = 1'b1;
            end
            step(c < 30, rand_row(), 0, 1, 0);
        end
        total++;
        if ({popped, lastmask} !== {32'd30, 32'h40100400}) begin
            bad++; $display("FAIL frame_last_positions got=%0d/%h want=30/40100400", popped, lastmask);
        end
    endtask

    task automatic test_backpressure();
        SHIFT_i = 4'd1; BIAS_i = '0;
        step(0, '0, 0, 0, 1);
        for (int c = 0; c < 20; c++) begin
            step(c < 18, rand_row(), 0, 0, 0);
            total++;
            if ({OUT_VAL_o, LEVEL_o, DROP_o} !== {mq.size() != 0, 5'(mq.size()), drop_m}) begin
                bad++; $display("FAIL bp_fill c=%0d got=%h want=%h", c,
                                {OUT_VAL_o, LEVEL_o, DROP_o}, {mq.size() != 0, 5'(mq.size()), drop_m});
            end
        end
        total++;
        if ({LEVEL_o, DROP_o} !== {5'd16, 1'b1}) begin
            bad++; $display("FAIL bp_full got=%h want=%h", {LEVEL_o, DROP_o}, {5'd16, 1'b1});
        end
        for (int c = 0; c < DEPTH + 2 && OUT_VAL_o; c++) begin
            total++;
            if (mq.size() == 0 || {OUT_LAST_o, OUT_SAT_o, OUT_o} !== {mq[0].last, mq[0].sat, mq[0].d}) begin
                bad++; $display("FAIL bp_drain c=%0d got=%h", c, {OUT_LAST_o, OUT_SAT_o, OUT_o});
            end
            step(0, '0, 0, 1, 0);
        end
        total++;
        if ({OUT_VAL_o, LEVEL_o, DROP_o} !== {1'b0, 5'd0, 1'b1}) begin
            bad++; $display("FAIL bp_empty got=%h want=%h", {OUT_VAL_o, LEVEL_o, DROP_o}, {1'b0, 5'd0, 1'b1});
        end
    endtask

    task automatic test_clr();
        int          popped = 0;
        logic [31:0] lastmask = '0;
        for (int c = 0; c < 7; c++) step(c < 5, rand_row(), 0, 0, 0);
        step(1, rand_row(), 0, 0, 0);
        step(1, rand_row(), 0, 0, 0);
        step(1, rand_row(), 0, 0, 1);
        total++;
        if ({OUT_VAL_o, LEVEL_o, DROP_o} !== 7'd0) begin
            bad++; $display("FAIL clr_state got=%h want=0", {OUT_VAL_o, LEVEL_o, DROP_o});
        end
        for (int c = 0; c < 16; c++) begin
            if (c >= 4) begin
                total++;
                if ({OUT_VAL_o, LEVEL_o} !== {mq.size() != 0, 5'(mq.size())}) begin
                    bad++; $display("FAIL clr_after c=%0d got=%h want=%h", c,
                                    {OUT_VAL_o, LEVEL_o}, {mq.size() != 0, 5'(mq.size())});
                end
            end
            if (OUT_VAL_o) begin
                popped++;
                if (OUT_LAST_o && popped < 32) lastmask[popped] = 1'b1;
            end
            step(c >= 4 && c < 14, rand_row(), 0, 1, 0);
        end
        for (int c = 0; c < 4; c++) begin
            if (OUT_VAL_o) begin
                popped++;
                if (OUT_LAST_o && popped < 32) lastmask[popped] = 1'b1;
            end
            step(0, '0, 0, 1, 0);
        end
        total++;
        if ({popped, lastmask} !== {32'd10, 32'h00000400}) begin
            bad++; $display("FAIL clr_frame got=%0d/%h want=10/00000400", popped, lastmask);
        end
    endtask

    task automatic test_full_pop_push();
        step(0, '0, 0, 0, 1);
        for (int c = 0; c < 18; c++) step(c < 16, rand_row(), 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            step(c < 2, rand_row(), 0, c >= 2, 0);
            total++;
            if ({LEVEL_o, DROP_o} !== {5'd16, 1'b0}) begin
                bad++; $display("FAIL full_pop_push c=%0d got=%h want=%h", c, {LEVEL_o, DROP_o}, {5'd16, 1'b0});
            end
        end
        for (int c = 0; c < DEPTH + 2 && OUT_VAL_o; c++) begin
            total++;
            if (mq.size() == 0 || {OUT_LAST_o, OUT_SAT_o, OUT_o} !== {mq[0].last, mq[0].sat, mq[0].d}) begin
                bad++; $display("FAIL fpp_drain c=%0d got=%h", c, {OUT_LAST_o, OUT_SAT_o, OUT_o});
            end
            step(0, '0, 0, 1, 0);
        end
    endtask

    task automatic test_back_to_back();
        step(0, '0, 0, 1, 1);
        for (int blk = 0; blk < 6; blk++) begin
            SHIFT_i = 4'($urandom_range(0, 15));
            RELU_i  = 1'($urandom_range(0, 1));
            for (int l = 0; l < 5; l++) BIAS_i[16*l +: 16] = 16'($urandom_range(0, 2000) - 1000);
            for (int c = 0; c < 62; c++) begin
                total++;
                if ({OUT_VAL_o, LEVEL_o, DROP_o} !== {mq.size() != 0, 5'(mq.size()), drop_m}) begin
                    bad++; $display("FAIL b2b_level b=%0d c=%0d got=%h want=%h", blk, c,
                                    {OUT_VAL_o, LEVEL_o, DROP_o}, {mq.size() != 0, 5'(mq.size()), drop_m});
                end
                if (mq.size() > 0) begin
                    total++;
                    if ({OUT_LAST_o, OUT_SAT_o, OUT_o} !== {mq[0].last, mq[0].sat, mq[0].d}) begin
                        bad++; $display("FAIL b2b_head b=%0d c=%0d got=%h want=%h", blk, c,
                                        {OUT_LAST_o, OUT_SAT_o, OUT_o}, {mq[0].last, mq[0].sat, mq[0].d});
                    end
                end
                step(c < 60 && $urandom_range(0, 9) < 7, rand_row(), $urandom_range(0, 9) == 0,
                     $urandom_range(0, 9) < 6, c < 60 && $urandom_range(0, 63) == 0);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, '0, 0, 0, 1);
        for (int c = 0; c < 6; c++) step(c < 4, rand_row(), 0, 0, 0);
        total++;
        if ({OUT_VAL_o, LEVEL_o} !== {1'b1, 5'd4}) begin
            bad++; $display("FAIL arst_pre got=%h want=%h", {OUT_VAL_o, LEVEL_o}, {1'b1, 5'd4});
        end
        #2 RSTN = 1'b0;
        #1;
        total++;
        if ({OUT_o, OUT_SAT_o, OUT_LAST_o, OUT_VAL_o, DROP_o, LEVEL_o} !== 49'd0) begin
            bad++; $display("FAIL arst_immediate got=%h want=0",
                            {OUT_o, OUT_SAT_o, OUT_LAST_o, OUT_VAL_o, DROP_o, LEVEL_o});
        end
        mq.delete(); p1v = 0; p2v = 0; fcnt = 0; drop_m = 0;
        @(posedge CLK); #1;
        RSTN = 1'b1;
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        total++;
        if ({OUT_VAL_o, LEVEL_o} !== 6'd0) begin
            bad++; $display("FAIL arst_after got=%h want=0", {OUT_VAL_o, LEVEL_o});
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        test_reset();
        RSTN = 1'b1;
        step(0, '0, 0, 0, 0);
        test_reset();
        test_directed();
        test_sat_relu();
        test_frame();
        test_backpressure();
        test_clr();
        test_full_pop_push();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1);
    end
endmodule
